draw_polyline_seq: RTL and testbench

DRAW_POLYLINE_SEQ -- requirements
Module: draw_polyline_seq

---
 rtl/draw_polyline_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_draw_polyline_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_polyline_seq.sv
// Polyline sequencer: reads vertices from a local RAM and issues one line request per segment.
// Define DRAW_POLYLINE_CLOSED_EN to enable the optional closing segment (last vertex back to vertex 0).
module draw_polyline_seq #(
  parameter int C_COORD_BITS = 16,
  parameter int C_COLOR_BITS = 16,
  parameter int C_DEPTH_BITS = 6
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr,
  input  logic [C_DEPTH_BITS-1:0]   waddr,
  input  logic [2*C_COORD_BITS-1:0] wdata,
  input  logic [C_DEPTH_BITS:0]     len,
  input  logic [C_COLOR_BITS-1:0]   color,
  input  logic                      closed,
  input  logic                      plot,
  output logic                      busy,
  output logic [C_COORD_BITS-1:0]   line_x0,
  output logic [C_COORD_BITS-1:0]   line_y0,
  output logic [C_COORD_BITS-1:0]   line_x1,
  output logic [C_COORD_BITS-1:0]   line_y1,
  output logic [C_COLOR_BITS-1:0]   line_color,
  output logic                      line_plot,
  input  logic                      line_busy
);

  localparam int VW    = 2 * C_COORD_BITS;
  localparam int DEPTH = 1 << C_DEPTH_BITS;
  localparam int LW    = C_DEPTH_BITS + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH  = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [VW-1:0]           mem [DEPTH];
  logic [VW-1:0]           rd_data_p1;
  logic                    vld_p1;
  logic                    rd_en;
  logic [C_DEPTH_BITS-1:0] rd_addr;

  logic                    plot_q;
  logic                    armed;
  logic                    start;
  logic [LW-1:0]           len_clamp;
  logic [LW-1:0]           len_q;
  logic [LW-1:0]           idx;
  logic [LW-1:0]           idx_inc;
  logic [C_COLOR_BITS-1:0] color_q;
  logic [VW-1:0]           prev_q;
  logic [VW-1:0]           cur_q;

  logic load_first;
  logic load_cur;
  logic issue_close;
  logic advance;
  logic close_pending;

`ifdef DRAW_POLYLINE_CLOSED_EN
  logic          closed_q;
  logic          closing_q;
  logic [VW-1:0] first_q;

  assign close_pending = closed_q && !closing_q;
`else
  logic unused_closed;

  assign unused_closed = closed;
  assign close_pending = 1'b0;
`endif

  // A plot already high when reset releases must go low once before it can start a run.
  assign start     = (state == IDLE) && plot && !plot_q && armed;
  assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  assign idx_inc   = idx + LW'(1);

  assign busy      = (state != IDLE);
  assign line_plot = (state == ISSUE);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle strobes; every fetch spends one cycle issuing the read
  // and one cycle capturing the RAM output once vld_p1 marks it valid.
  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    rd_addr     = idx[C_DEPTH_BITS-1:0];
    load_first  = 1'b0;
    load_cur    = 1'b0;
    issue_close = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len_clamp <= LW'(1)) ? DONE : FETCH0;
        end
      end
      FETCH0: begin
        rd_addr = '0;
        if (!vld_p1) begin
          rd_en = 1'b1;
        end else begin
          load_first = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        if (!vld_p1) begin
          rd_en = 1'b1;
        end else begin
          load_cur  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (line_busy) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!line_busy) begin
          advance = 1'b1;
          if (idx_inc < len_q) begin
            state_nxt = FETCH;
          end else if (close_pending) begin
            issue_close = 1'b1;
            state_nxt   = ISSUE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control registers and segment outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_q     <= 1'b0;
      armed      <= 1'b0;
      vld_p1     <= 1'b0;
      len_q      <= '0;
      color_q    <= '0;
      idx        <= '0;
      line_x0    <= '0;
      line_y0    <= '0;
      line_x1    <= '0;
      line_y1    <= '0;
      line_color <= '0;
`ifdef DRAW_POLYLINE_CLOSED_EN
      closed_q   <= 1'b0;
      closing_q  <= 1'b0;
`endif
    end else begin
      plot_q <= plot;
      if (!plot) begin
        armed <= 1'b1;
      end
      vld_p1 <= rd_en;
      if (start) begin
        len_q   <= len_clamp;
        color_q <= color;
        idx     <= LW'(1);
`ifdef DRAW_POLYLINE_CLOSED_EN
        closed_q  <= closed;
        closing_q <= 1'b0;
`endif
      end
      if (advance) begin
        idx <= idx_inc;
      end
      if (load_cur) begin
        line_x0    <= prev_q[VW-1 -: C_COORD_BITS];
        line_y0    <= prev_q[C_COORD_BITS-1:0];
        line_x1    <= rd_data_p1[VW-1 -: C_COORD_BITS];
        line_y1    <= rd_data_p1[C_COORD_BITS-1:0];
        line_color <= color_q;
      end
`ifdef DRAW_POLYLINE_CLOSED_EN
      if (issue_close) begin
        closing_q  <= 1'b1;
        line_x0    <= cur_q[VW-1 -: C_COORD_BITS];
        line_y0    <= cur_q[C_COORD_BITS-1:0];
        line_x1    <= first_q[VW-1 -: C_COORD_BITS];
        line_y1    <= first_q[C_COORD_BITS-1:0];
        line_color <= color_q;
      end
`endif
    end
  end

  // Vertex RAM and vertex datapath (no reset on data)
  always_ff @(posedge clk) begin
    if (wr && !busy) begin
      mem[waddr] <= wdata;
    end
    if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
    if (load_first) begin
      prev_q <= rd_data_p1;
    end else if (advance) begin
      prev_q <= cur_q;
    end
    if (load_cur) begin
      cur_q <= rd_data_p1;
    end
`ifdef DRAW_POLYLINE_CLOSED_EN
    if (load_first) begin
      first_q <= rd_data_p1;
    end
`endif
  end

endmodule

// File: tb/tb_draw_polyline_seq.sv
// Scoreboard bench for draw_polyline_seq with a behavioural downstream line drawer.
module tb_draw_polyline_seq;

  localparam int CB = 16;
  localparam int KB = 16;
  localparam int DB = 6;
  localparam int HOLD = 20;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            wr = 1'b0;
  logic [DB-1:0]   waddr = '0;
  logic [2*CB-1:0] wdata = '0;
  logic [DB:0]     len = '0;
  logic [KB-1:0]   color = '0;
  logic            closed = 1'b0;
  logic            plot = 1'b0;
  logic            line_busy = 1'b0;
  logic            busy;
  logic [CB-1:0]   line_x0, line_y0, line_x1, line_y1;
  logic [KB-1:0]   line_color;
  logic            line_plot;

  draw_polyline_seq #(.C_COORD_BITS(CB), .C_COLOR_BITS(KB), .C_DEPTH_BITS(DB)) dut (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .wdata(wdata), .len(len),
    .color(color), .closed(closed), .plot(plot), .busy(busy),
    .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
    .line_color(line_color), .line_plot(line_plot), .line_busy(line_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int seg_count = 0;
  logic [79:0] sb[$];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] seg(input int x0, input int y0, input int x1, input int y1,
                                      input int c);
    return {16'(x0), 16'(y0), 16'(x1), 16'(y1), 16'(c)};
  endfunction

  function automatic logic [79:0] outs();
    return {line_x0, line_y0, line_x1, line_y1, line_color};
  endfunction

  task automatic wv(input int a, input int x, input int y);
    @(negedge clk);
    wr = 1'b1; waddr = DB'(a); wdata = {16'(x), 16'(y)};
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic run(output int cyc);
    @(negedge clk); plot = 1'b1;
    @(negedge clk); plot = 1'b0;
    cyc = 0;
    for (int t = 0; t < 3000 && busy; t++) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_end", {79'd0, busy}, 80'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {79'd0, busy}, 80'd0);
    check({tag, "_lplot"}, {79'd0, line_plot}, 80'd0);
    check({tag, "_lines"}, outs(), 80'd0);
  endtask

  // Downstream drawer: line_busy 3 cycles after line_plot, held HOLD cycles
  initial begin : drawer
    logic        aborted;
    logic [79:0] got;
    logic [79:0] exp;
    forever begin
      @(negedge clk);
      if (resetn && line_plot) begin
        got = outs();
        seg_count++;
        exp = (sb.size() != 0) ? sb.pop_front() : {80{1'b1}};
        check("segment", got, exp);
        aborted = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (!aborted) begin
            @(negedge clk);
            if (!resetn) aborted = 1'b1;
          end
        end
        if (!aborted) begin
          check("plot_held", {79'd0, line_plot}, 80'd1);
          line_busy = 1'b1;
        end
        for (int k = 0; k < HOLD; k++) begin
          if (!aborted) begin
            @(negedge clk);
            if (!resetn) aborted = 1'b1;
          end
        end
        if (!aborted) begin
          check("stable", outs(), got);
          check("plot_low_wait", {79'd0, line_plot}, 80'd0);
          check("busy_in_seg", {79'd0, busy}, 80'd1);
        end
        line_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    int s0;
    int found;
    #1;
    check_zero("reset0");
    repeat (2) @(negedge clk);
    check_zero("reset1");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // open polyline of three vertices
    wv(0, 10, 20); wv(1, 100, 20); wv(2, 100, 200);
    len = 7'd3; closed = 1'b0; color = 16'h1234;
    s0 = seg_count;
    sb.push_back(seg(10, 20, 100, 20, 16'h1234));
    sb.push_back(seg(100, 20, 100, 200, 16'h1234));
    run(cyc);
    check("nseg_open", 80'(seg_count - s0), 80'd2);

    // same vertices with closing requested
    closed = 1'b1; color = 16'hBEEF;
    s0 = seg_count;
    sb.push_back(seg(10, 20, 100, 20, 16'hBEEF));
    sb.push_back(seg(100, 20, 100, 200, 16'hBEEF));
`ifdef DRAW_POLYLINE_CLOSED_EN
    sb.push_back(seg(100, 200, 10, 20, 16'hBEEF));
    run(cyc);
    check("nseg_closed", 80'(seg_count - s0), 80'd3);
`else
    run(cyc);
    check("nseg_closed", 80'(seg_count - s0), 80'd2);
`endif

    // degenerate lengths
    closed = 1'b1;
    for (int l = 0; l < 2; l++) begin
      len = 7'(l);
      s0 = seg_count;
      run(cyc);
      check("short_busy_cycles", 80'(cyc), 80'd1);
      check("short_nseg", 80'(seg_count - s0), 80'd0);
    end

    // plot and wr pulsed mid-segment must be ignored
    len = 7'd3; closed = 1'b0; color = 16'h0055;
    s0 = seg_count;
    sb.push_back(seg(10, 20, 100, 20, 16'h0055));
    sb.push_back(seg(100, 20, 100, 200, 16'h0055));
    fork
      run(cyc);
      begin
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
          @(negedge clk);
          if (line_busy) found = 1;
        end
        plot = 1'b1; wr = 1'b1; waddr = DB'(1); wdata = {16'd999, 16'd999};
        @(negedge clk);
        plot = 1'b0; wr = 1'b0;
      end
    join
    check("mid_found", 80'(found), 80'd1);
    check("nseg_mid", 80'(seg_count - s0), 80'd2);
    repeat (5) @(negedge clk);
    check("no_restart_mid", {79'd0, busy}, 80'd0);
    s0 = seg_count;
    sb.push_back(seg(10, 20, 100, 20, 16'h0055));
    sb.push_back(seg(100, 20, 100, 200, 16'h0055));
    run(cyc);
    check("ram_kept", 80'(seg_count - s0), 80'd2);

    // reset during the second of four segments with plot held high
    wv(0, 1, 2); wv(1, 3, 4); wv(2, 5, 6); wv(3, 7, 8); wv(4, 9, 10);
    len = 7'd5; closed = 1'b0; color = 16'h00AA;
    s0 = seg_count;
    sb.push_back(seg(1, 2, 3, 4, 16'h00AA));
    sb.push_back(seg(3, 4, 5, 6, 16'h00AA));
    sb.push_back(seg(5, 6, 7, 8, 16'h00AA));
    sb.push_back(seg(7, 8, 9, 10, 16'h00AA));
    @(negedge clk); plot = 1'b1;
    found = 0;
    for (int t = 0; t < 500 && !found; t++) begin
      @(negedge clk);
      if (seg_count == s0 + 2 && line_busy) found = 1;
    end
    check("reach_wait2", 80'(found), 80'd1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_zero("async_rst");
    sb.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    s0 = seg_count;
    cyc = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    check("no_restart_rst", 80'(cyc), 80'd0);
    check("no_seg_rst", 80'(seg_count - s0), 80'd0);
    plot = 1'b0;
    wv(0, 40, 50); wv(1, 60, 70); wv(2, 80, 90);
    len = 7'd3; color = 16'h0F0F;
    sb.push_back(seg(40, 50, 60, 70, 16'h0F0F));
    sb.push_back(seg(60, 70, 80, 90, 16'h0F0F));
    run(cyc);
    check("nseg_after_rst", 80'(seg_count - s0), 80'd2);

    check("sb_empty", 80'(sb.size()), 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
